// File: rtl/video_in_dma_if.sv
// ---------------------------------------------------------------------------
// video_in_dma_if
// Bundles the FIFO read side and the memory-bus write side of the video
// input DMA controller.
//   fifo_data  : FIFO head word (first-word-fall-through)
//   fifo_level : words currently stored in the FIFO
//   fifo_full  : FIFO full flag
//   fifo_re    : pop strobe from the controller
//   req        : bus write request
//   addr       : bus byte address
//   wdata      : bus write data
//   ack        : bus accept for the current word
// master = DMA controller, slave = FIFO + memory bus side.
// ---------------------------------------------------------------------------
interface video_in_dma_if #(
  parameter int p_LVL_W = 6
) ();
  logic [31:0]        fifo_data;
  logic [p_LVL_W-1:0] fifo_level;
  logic               fifo_full;
  logic               fifo_re;
  logic               req;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic               ack;

  modport master (
    input  fifo_data, fifo_level, fifo_full, ack,
    output fifo_re, req, addr, wdata
  );

  modport slave (
    output fifo_data, fifo_level, fifo_full, ack,
    input  fifo_re, req, addr, wdata
  );
endinterface

// File: rtl/video_in_dma_ctrl.sv
// ---------------------------------------------------------------------------
// video_in_dma_ctrl
// Write-side controller of the video input path. Drains the packed-pixel
// FIFO in fixed-length bursts of single-word bus writes, alternating whole
// frames between two frame buffers.
// Ports:
//   clk        : clock, rising edge
//   nRST       : asynchronous active-low reset
//   enable     : software run bit
//   base0/1    : frame buffer byte addresses (bits [1:0] ignored)
//   bus        : FIFO + memory bus interface (master modport)
//   busy       : high whenever the FSM is not IDLE
//   frame_done : one-cycle pulse after the last word of a frame
//   done_buf   : index of the last completed buffer
//   ovf        : sticky FIFO overflow flag, cleared while enable=0
// ---------------------------------------------------------------------------
module video_in_dma_ctrl #(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480,
  parameter int p_BURST  = 8,
  parameter int p_LVL_W  = 6
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                enable,
  input  logic [31:0]         base0,
  input  logic [31:0]         base1,
  video_in_dma_if.master      bus,
  output logic                busy,
  output logic                frame_done,
  output logic                done_buf,
  output logic                ovf
);

  localparam int N_WORDS = p_WIDTH * p_HEIGHT / 4;
  localparam int BC_W    = (p_BURST > 1) ? $clog2(p_BURST) : 1;

  localparam logic [16:0]        LAST_WORD = 17'(N_WORDS - 1);
  localparam logic [BC_W-1:0]    LAST_BEAT = BC_W'(p_BURST - 1);
  localparam logic [p_LVL_W-1:0] BURST_LVL = p_LVL_W'(p_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t          state;
  logic [16:0]     wcnt;
  logic [BC_W-1:0] bcnt;
  logic            cur_buf;
  logic            req;
  logic [31:0]     addr;

  logic            last_word;
  logic [16:0]     wcnt_nxt;
  logic            buf_nxt;
  logic            beat;

  // Byte address of word idx inside the selected buffer, wrapping mod 2^32.
  function automatic logic [31:0] word_addr(input logic        buf_sel,
                                            input logic [16:0] idx,
                                            input logic [31:0] b0,
                                            input logic [31:0] b1);
    logic [31:0] base;
    base = (buf_sel ? b1 : b0) & 32'hFFFF_FFFC;
    return base + {13'b0, idx, 2'b00};
  endfunction

  // A beat is one accepted word; acks without a pending request are ignored.
  assign beat      = req & bus.ack;
  assign last_word = (wcnt == LAST_WORD);
  assign wcnt_nxt  = last_word ? 17'd0 : (wcnt + 17'd1);
  assign buf_nxt   = last_word ? ~cur_buf : cur_buf;

  // Pop and write data follow the accepted word combinationally.
  assign bus.req     = req;
  assign bus.addr    = addr;
  assign bus.fifo_re = beat;
  assign bus.wdata   = req ? bus.fifo_data : 32'h0000_0000;

  // Control FSM with all registered outputs and counters.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      wcnt       <= 17'd0;
      bcnt       <= '0;
      cur_buf    <= 1'b0;
      req        <= 1'b0;
      addr       <= 32'h0000_0000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      done_buf   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Overflow does not stall the transfer; software clears it by
      // dropping enable.
      if (!enable) begin
        ovf <= 1'b0;
      end else if (bus.fifo_full) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= WAIT;
            busy    <= 1'b1;
            wcnt    <= 17'd0;
            bcnt    <= '0;
            cur_buf <= 1'b0;
            addr    <= word_addr(1'b0, 17'd0, base0, base1);
          end else begin
            busy <= 1'b0;
            req  <= 1'b0;
            addr <= 32'h0000_0000;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            addr  <= 32'h0000_0000;
          end else begin
            // Re-evaluated every cycle so a base change before the burst
            // starts is picked up.
            addr <= word_addr(cur_buf, wcnt, base0, base1);
            if (bus.fifo_level >= BURST_LVL) begin
              state <= BURST;
              req   <= 1'b1;
            end else begin
              req <= 1'b0;
            end
          end
        end

        BURST: begin
          if (beat) begin
            wcnt    <= wcnt_nxt;
            cur_buf <= buf_nxt;
            addr    <= word_addr(buf_nxt, wcnt_nxt, base0, base1);
            if (last_word) begin
              frame_done <= 1'b1;
              done_buf   <= cur_buf;
            end else begin
              done_buf <= done_buf;
            end
            // enable is only honoured at the burst boundary.
            if (bcnt == LAST_BEAT) begin
              bcnt <= '0;
              req  <= 1'b0;
              if (enable) begin
                state <= WAIT;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                addr  <= 32'h0000_0000;
              end
            end else begin
              bcnt <= bcnt + BC_W'(1);
            end
          end else begin
            req <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
          bcnt  <= '0;
          addr  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_in_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_in_dma_ctrl
// Directed bench for video_in_dma_ctrl with a reduced frame (32x2 pixels =
// 16 words = 2 bursts) so full-frame and buffer-toggle cases stay short.
// A vector table covers reset, the WAIT level threshold, the first burst and
// overflow; hand-written sequences cover stalls, frame ends, enable drop and
// reset mid-burst.
// ---------------------------------------------------------------------------
module tb_video_in_dma_ctrl;

  localparam int    WIDTH  = 32;
  localparam int    HEIGHT = 2;
  localparam int    BURST  = 8;
  localparam int    LVL_W  = 6;
  localparam int    NWORDS = WIDTH * HEIGHT / 4;
  localparam logic [31:0] BASE0 = 32'h0000_1000;
  localparam logic [31:0] BASE1 = 32'h0008_0000;
  localparam logic [31:0] DATA0 = 32'hA500_0000;

  logic        clk;
  logic        nRST;
  logic        enable;
  logic [31:0] base0;
  logic [31:0] base1;
  logic        busy;
  logic        frame_done;
  logic        done_buf;
  logic        ovf;
  logic [31:0] pop_cnt = 32'd0;

  video_in_dma_if #(.p_LVL_W(LVL_W)) bus ();

  video_in_dma_ctrl #(
    .p_WIDTH (WIDTH),
    .p_HEIGHT(HEIGHT),
    .p_BURST (BURST),
    .p_LVL_W (LVL_W)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .enable    (enable),
    .base0     (base0),
    .base1     (base1),
    .bus       (bus),
    .busy      (busy),
    .frame_done(frame_done),
    .done_buf  (done_buf),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: the head word carries its pop index.
  assign bus.fifo_data = DATA0 + pop_cnt;
  always_ff @(posedge clk) begin
    if (bus.fifo_re) pop_cnt <= pop_cnt + 32'd1;
  end

  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the transfer position.
  int   m_wcnt = 0;
  int   m_acks = 0;
  logic m_buf  = 1'b0;
  logic m_db   = 1'b0;
  logic m_fd   = 1'b0;
  logic m_ovf  = 1'b0;

  typedef struct {
    logic        en;
    logic [5:0]  lvl;
    logic        full;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_re;
    logic        e_busy;
    logic        e_ovf;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_addr();
    return (m_buf ? BASE1 : BASE0) + 32'(m_wcnt * 4);
  endfunction

  function automatic logic [31:0] exp_wdata();
    return DATA0 + 32'(m_acks);
  endfunction

  task automatic model_ack();
    m_acks++;
    m_wcnt++;
    if (m_wcnt == NWORDS) begin
      m_wcnt = 0;
      m_fd   = 1'b1;
      m_db   = m_buf;
      m_buf  = ~m_buf;
    end
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    bus.fifo_level = 6'd8;
    bus.ack = 1'b0;
    #1;
    while (bus.req !== 1'b1 && t < 20) begin
      tick();
      #1;
      t++;
    end
    chk("req_rise", {31'd0, bus.req}, 32'd1);
    chk("req_addr", bus.addr, exp_addr());
  endtask

  // One full burst with random stalls; optionally drops enable on beat drop_at.
  task automatic run_burst(input int stall_max, input int drop_at);
    int stalls;
    m_fd = 1'b0;
    wait_req();
    for (int k = 0; k < BURST; k++) begin
      stalls = int'($urandom_range(stall_max, 0));
      for (int s = 0; s < stalls; s++) begin
        bus.ack = 1'b0;
        #1;
        chk("stall_req",   {31'd0, bus.req}, 32'd1);
        chk("stall_addr",  bus.addr, exp_addr());
        chk("stall_wdata", bus.wdata, exp_wdata());
        chk("stall_re",    {31'd0, bus.fifo_re}, 32'd0);
        tick();
      end
      bus.ack = 1'b1;
      if (k == drop_at) begin
        enable = 1'b0;
        m_ovf  = 1'b0;
      end
      #1;
      chk("beat_req",   {31'd0, bus.req}, 32'd1);
      chk("beat_addr",  bus.addr, exp_addr());
      chk("beat_wdata", bus.wdata, exp_wdata());
      chk("beat_re",    {31'd0, bus.fifo_re}, 32'd1);
      chk("beat_fd",    {31'd0, frame_done}, 32'd0);
      tick();
      model_ack();
    end
    bus.ack = 1'b0;
    bus.fifo_level = 6'd0;
    #1;
    chk("gap_req",    {31'd0, bus.req}, 32'd0);
    chk("gap_re",     {31'd0, bus.fifo_re}, 32'd0);
    chk("gap_wdata",  bus.wdata, 32'd0);
    chk("fd_pulse",   {31'd0, frame_done}, {31'd0, m_fd});
    chk("done_buf",   {31'd0, done_buf}, {31'd0, m_db});
    chk("busy_after", {31'd0, busy}, {31'd0, enable});
    chk("ovf_state",  {31'd0, ovf}, {31'd0, m_ovf});
    if (enable) chk("next_addr", bus.addr, exp_addr());
    tick();
    #1;
    chk("fd_width", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    // Vector table: one entry per clock, outputs checked mid-cycle.
    tbl[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < BURST; k++) begin
      tbl[5 + k] = '{1'b1, 6'd8, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(4 * k),
                     DATA0 + 32'(k), 1'b1, 1'b1, 1'b0};
    end
    tbl[13] = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 32'h1020, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 32'h1020, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 32'h1020, 32'h0, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 32'h1020, 32'h0, 1'b0, 1'b1, 1'b1};

    nRST = 1'b0;
    enable = 1'b0;
    base0 = BASE0;
    base1 = BASE1;
    bus.fifo_level = 6'd0;
    bus.fifo_full = 1'b0;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",  {31'd0, bus.req}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      enable         = tbl[i].en;
      bus.fifo_level = tbl[i].lvl;
      bus.fifo_full  = tbl[i].full;
      bus.ack        = tbl[i].ack;
      #1;
      chk("tbl_req",   {31'd0, bus.req}, {31'd0, tbl[i].e_req});
      chk("tbl_addr",  bus.addr, tbl[i].e_addr);
      chk("tbl_wdata", bus.wdata, tbl[i].e_wdata);
      chk("tbl_re",    {31'd0, bus.fifo_re}, {31'd0, tbl[i].e_re});
      chk("tbl_busy",  {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk("tbl_ovf",   {31'd0, ovf}, {31'd0, tbl[i].e_ovf});
      chk("tbl_fd",    {31'd0, frame_done}, 32'd0);
      chk("tbl_dbuf",  {31'd0, done_buf}, 32'd0);
      tick();
    end
    m_wcnt = 8;
    m_acks = 8;
    m_ovf  = 1'b1;

    // Second half of frame 0 with stalls, then frame 1 into base1.
    run_burst(3, -1);
    run_burst(0, -1);
    run_burst(2, -1);

    // Dropping enable clears the sticky overflow.
    enable = 1'b0;
    m_ovf  = 1'b0;
    tick();
    #1;
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_req",  {31'd0, bus.req}, 32'd0);

    // Enable drop on the third beat must not truncate the burst.
    enable = 1'b1;
    m_wcnt = 0;
    m_buf  = 1'b0;
    run_burst(1, 2);

    // Re-enable restarts at base0, word 0.
    enable = 1'b1;
    m_wcnt = 0;
    m_buf  = 1'b0;
    run_burst(0, -1);

    // Reset in the middle of a burst.
    wait_req();
    for (int k = 0; k < 3; k++) begin
      bus.ack = 1'b1;
      #1;
      chk("pre_rst_addr", bus.addr, exp_addr());
      tick();
      model_ack();
    end
    nRST = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus.req}, 32'd0);
    chk("arst_re",    {31'd0, bus.fifo_re}, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_addr",  bus.addr, 32'd0);
    chk("arst_wdata", bus.wdata, 32'd0);
    tick();
    tick();
    bus.ack = 1'b0;
    nRST = 1'b1;
    m_wcnt = 0;
    m_buf  = 1'b0;
    m_db   = 1'b0;
    m_ovf  = 1'b0;
    run_burst(0, -1);

    chk("pop_count", pop_cnt, 32'(m_acks));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_in_dma_ctrl.md
# video_in_dma_ctrl

Write-side controller for the video input path. It drains the 32-bit packed-pixel FIFO filled by the video input capture block and issues fixed-length bursts of single-word writes to the memory bus. Frames alternate between two software-configured frame buffers. It reports frame completion and FIFO overflow to the processor.

## Interface
Parameters:
- p_WIDTH, 640, active pixels per line
- p_HEIGHT, 480, active lines per frame
- p_BURST, 8, words per burst; p_WIDTH*p_HEIGHT/4 must be a multiple of p_BURST
- p_LVL_W, 6, width of the FIFO level input

Ports:
- clk  in  1  clock; all logic on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- enable  in  1  software run bit
- base0, base1  in  32 each  frame buffer byte addresses; bits [1:0] are ignored and treated as 0
- fifo_data  in  32  FIFO head word (first-word-fall-through)
- fifo_level  in  p_LVL_W  words currently stored in the FIFO
- fifo_full  in  1  FIFO full
- fifo_re  out  1  pop strobe
- req  out  1  bus write request
- addr  out  32  bus byte address
- wdata  out  32  bus write data
- ack  in  1  bus accept for the current word
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at the end of each frame
- done_buf  out  1  index of the last completed buffer
- ovf  out  1  sticky overflow flag

## Operation
- Words per frame: N = p_WIDTH*p_HEIGHT/4 (76800 at the defaults). The word counter wcnt is 17 bits wide.
- Address rule: addr = (cur_buf ? base1 : base0) + 4*wcnt, computed modulo 2^32.
- FSM states: IDLE, WAIT, BURST.
  - IDLE → WAIT when enable=1. On this transition wcnt=0 and cur_buf=0.
  - WAIT → BURST when fifo_level ≥ p_BURST and enable=1.
  - WAIT → IDLE when enable=0.
  - BURST: req=1. Each cycle with ack=1 transfers one word.
  - BURST → WAIT after the p_BURST-th ack if enable=1, otherwise → IDLE.
- An enable drop during BURST never truncates the burst. It takes effect only at the burst end.
- Word transfer:
  - fifo_re = req & ack (combinational).
  - wdata = fifo_data (combinational) while req=1, otherwise 0.
  - wcnt increments on every ack. The burst counter bcnt (0..p_BURST-1) also increments on every ack.
- Frame end: on the ack of word N-1:
  - wcnt wraps to 0.
  - cur_buf toggles.
  - frame_done pulses on the next cycle.
  - done_buf is set to the old cur_buf.
- ovf is set on any cycle with fifo_full=1 and enable=1. It is cleared only while enable=0 or by reset. Overflow does not stop the transfer.
- fifo_re is never asserted when req=0. The bus must not ack while req=0; any such ack is ignored.

## Timing
- Reset values: fifo_re=0, req=0, addr=0, wdata=0, busy=0, frame_done=0, done_buf=0, ovf=0. Internally state=IDLE, wcnt=0, bcnt=0, cur_buf=0.
- IDLE→WAIT takes 1 cycle after enable is sampled high. WAIT→BURST takes 1 cycle after the level condition is met, so req rises one cycle after the condition.
- addr, req and bcnt are registered. After an ack in cycle t, addr advances by 4 in cycle t+1.
- Throughput is 1 word per cycle with ack held high. Minimum burst duration is p_BURST cycles.
- req stays high with addr and wdata stable until ack is sampled. Wait states of any length are allowed.
- Between consecutive bursts there is at least 1 cycle in WAIT with req=0.
- frame_done is high for exactly 1 cycle, at t+1 after the last-word ack in cycle t. done_buf updates in the same cycle.
- Asynchronous reset mid-burst: all outputs return to their reset values immediately. The partial frame is abandoned and the next frame starts at base0.

## Test plan
- Reset, then enable=1 with fifo_level=7 → stays in WAIT, req=0. Raise the level to 8 → req=1 one cycle later, addr=base0.
- base0=0x1000, ack held high, 8 words → addr sequence 0x1000..0x101C, 8 fifo_re pulses, then one cycle in WAIT with req=0.
- Random ack stalls of 0-3 cycles → each word appears exactly once, addr and wdata stay stable during stalls, and fifo_re count equals the number of acks.
- Full frame, base1=0x80000 → frame_done pulses once after the 76800th ack with done_buf=0. The next word goes to 0x80000. After a second frame, done_buf=1 and writes resume at base0.
- enable dropped at the 3rd word of a burst → all 8 words still transfer, then IDLE with busy=0. Re-enable → writes restart at base0 with wcnt=0.
- fifo_full pulsed for 1 cycle → ovf=1 and held. enable=0 → ovf=0. nRST asserted mid-burst → req=0 and fifo_re=0 immediately.
